// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one main-memory port between the I-cache (read-only)
// and the D-cache (read/write). Round-robin grant, one transaction in flight,
// registered memory strobes and requester responses, and a watchdog that
// aborts a transaction whose memory ack never arrives.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              busy,
    output logic              timeout_err,
    output logic              err
);

    // Watchdog counter wide enough to hold TIMEOUT-1; the abort fires on the
    // edge that ends the TIMEOUT-th BUSY cycle.
    localparam int               CNT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam bit               WD_EN    = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = WD_EN ? CNT_W'(TIMEOUT - 1) : {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_BUSY_I = 3'd1,
        ST_BUSY_D = 3'd2,
        ST_RESP_I = 3'd3,
        ST_RESP_D = 3'd4
    } state_t;

    state_t           r_state;
    logic             r_last_d;   // 1: the most recent grant went to the D-cache
    logic [CNT_W-1:0] r_cnt;

    logic             w_grant_i;
    logic             w_grant_d;
    logic             w_timeout;
    logic             w_is_d;

    // Round-robin grant decision: a tie goes to the requester not served last.
    always_comb begin
        w_grant_i = 1'b0;
        w_grant_d = 1'b0;
        if (i_req && d_req) begin
            if (r_last_d) begin
                w_grant_i = 1'b1;
            end else begin
                w_grant_d = 1'b1;
            end
        end else if (i_req) begin
            w_grant_i = 1'b1;
        end else if (d_req) begin
            w_grant_d = 1'b1;
        end else begin
            w_grant_i = 1'b0;
            w_grant_d = 1'b0;
        end
    end

    // Watchdog expiry and which side owns the transaction in flight.
    always_comb begin
        w_timeout = 1'b0;
        w_is_d    = 1'b0;
        if (WD_EN && (r_cnt == CNT_LAST)) begin
            w_timeout = 1'b1;
        end else begin
            w_timeout = 1'b0;
        end
        if (r_state == ST_BUSY_D) begin
            w_is_d = 1'b1;
        end else begin
            w_is_d = 1'b0;
        end
    end

    // Arbitration FSM with all memory-side and requester-side outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_last_d    <= 1'b1;
            r_cnt       <= {CNT_W{1'b0}};
            i_ack       <= 1'b0;
            i_rdata     <= {DATA_W{1'b0}};
            d_ack       <= 1'b0;
            d_rdata     <= {DATA_W{1'b0}};
            mem_rd_en   <= 1'b0;
            mem_wr_en   <= 1'b0;
            mem_addr    <= {ADDR_W{1'b0}};
            mem_wdata   <= {DATA_W{1'b0}};
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            err         <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= {CNT_W{1'b0}};
                    i_ack <= 1'b0;
                    d_ack <= 1'b0;
                    err   <= 1'b0;
                    if (w_grant_i) begin
                        mem_addr  <= i_addr;
                        mem_rd_en <= 1'b1;
                        mem_wr_en <= 1'b0;
                        r_last_d  <= 1'b0;
                        busy      <= 1'b1;
                        r_state   <= ST_BUSY_I;
                    end else if (w_grant_d) begin
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        mem_rd_en <= ~d_we;
                        mem_wr_en <= d_we;
                        r_last_d  <= 1'b1;
                        busy      <= 1'b1;
                        r_state   <= ST_BUSY_D;
                    end else begin
                        mem_rd_en <= 1'b0;
                        mem_wr_en <= 1'b0;
                        busy      <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                ST_BUSY_I, ST_BUSY_D: begin
                    // mem_ack is checked first so it wins over a coincident expiry.
                    if (mem_ack) begin
                        mem_rd_en <= 1'b0;
                        mem_wr_en <= 1'b0;
                        err       <= 1'b0;
                        r_cnt     <= {CNT_W{1'b0}};
                        if (w_is_d) begin
                            d_rdata <= mem_rdata;
                            d_ack   <= 1'b1;
                            r_state <= ST_RESP_D;
                        end else begin
                            i_rdata <= mem_rdata;
                            i_ack   <= 1'b1;
                            r_state <= ST_RESP_I;
                        end
                    end else if (w_timeout) begin
                        mem_rd_en   <= 1'b0;
                        mem_wr_en   <= 1'b0;
                        err         <= 1'b1;
                        timeout_err <= 1'b1;
                        r_cnt       <= {CNT_W{1'b0}};
                        if (w_is_d) begin
                            d_rdata <= {DATA_W{1'b0}};
                            d_ack   <= 1'b1;
                            r_state <= ST_RESP_D;
                        end else begin
                            i_rdata <= {DATA_W{1'b0}};
                            i_ack   <= 1'b1;
                            r_state <= ST_RESP_I;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                ST_RESP_I, ST_RESP_D: begin
                    i_ack   <= 1'b0;
                    d_ack   <= 1'b0;
                    err     <= 1'b0;
                    busy    <= 1'b0;
                    r_cnt   <= {CNT_W{1'b0}};
                    r_state <= ST_IDLE;
                end
                default: begin
                    i_ack     <= 1'b0;
                    d_ack     <= 1'b0;
                    err       <= 1'b0;
                    busy      <= 1'b0;
                    mem_rd_en <= 1'b0;
                    mem_wr_en <= 1'b0;
                    r_cnt     <= {CNT_W{1'b0}};
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected memory
// transactions and requester responses; a monitor pops and compares them
// whenever a strobe starts/ends or an ack is presented.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        mem_rd_en;
    logic        mem_wr_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        busy;
    logic        timeout_err;
    logic        err;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .busy(busy), .timeout_err(timeout_err), .err(err)
    );

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          dur;
    } mem_t;

    typedef struct {
        bit          is_d;
        logic [31:0] rdata;
        bit          err;
    } resp_t;

    mem_t  exp_mem[$];
    resp_t exp_resp[$];
    int    n_chk;
    int    n_err;
    int    n_resp;
    int    mem_lat;      // strobe cycles before the memory acks; 0 = never
    bit    idle_pulse;   // drive mem_ack while no strobe is active

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory model: address 0x100 returns 0xDEADBEEF, others {addr[15:0],16'hBEEF}.
    task automatic responder();
        int cnt;
        logic [31:0] a;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst && (mem_rd_en || mem_wr_en)) begin
                cnt++;
                a = mem_addr;
                if (mem_lat != 0 && cnt == mem_lat) begin
                    mem_ack   = 1'b1;
                    mem_rdata = (a == 32'h100) ? 32'hDEADBEEF : {a[15:0], 16'hBEEF};
                end else begin
                    mem_ack   = 1'b0;
                    mem_rdata = 32'h0;
                end
            end else begin
                cnt       = 0;
                mem_ack   = idle_pulse;
                mem_rdata = idle_pulse ? 32'hBAD0BAD0 : 32'h0;
            end
        end
    endtask

    task automatic monitor();
        bit   prev_stb;
        bit   stb;
        bit   have_cur;
        int   dur;
        mem_t cur;
        resp_t r;
        prev_stb = 1'b0;
        have_cur = 1'b0;
        dur      = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stb = 1'b0;
                have_cur = 1'b0;
            end else begin
                stb = mem_rd_en || mem_wr_en;
                if (mem_rd_en && mem_wr_en) chk("strobe_exclusive", 1, 0);
                if (stb && !prev_stb) begin
                    dur = 1;
                    if (exp_mem.size() == 0) begin
                        chk("mem_unexpected_strobe", 1, 0);
                    end else begin
                        cur = exp_mem.pop_front();
                        have_cur = 1'b1;
                        chk("mem_wr_en", mem_wr_en, cur.wr);
                        chk("mem_rd_en", mem_rd_en, !cur.wr);
                        chk("mem_addr", mem_addr, cur.addr);
                        if (cur.wr) chk("mem_wdata", mem_wdata, cur.wdata);
                    end
                end else if (stb) begin
                    dur++;
                    if (have_cur) chk("mem_addr_hold", mem_addr, cur.addr);
                end else if (prev_stb) begin
                    if (have_cur) chk("strobe_cycles", dur, cur.dur);
                    have_cur = 1'b0;
                end
                prev_stb = stb;
                if (i_ack || d_ack) begin
                    chk("ack_onehot", i_ack && d_ack, 0);
                    if (exp_resp.size() == 0) begin
                        chk("ack_unexpected", 1, 0);
                    end else begin
                        r = exp_resp.pop_front();
                        chk("ack_who_is_d", d_ack, r.is_d);
                        chk("resp_rdata", d_ack ? d_rdata : i_rdata, r.rdata);
                        chk("resp_err", err, r.err);
                        chk("busy_in_resp", busy, 1);
                    end
                    n_resp++;
                end
            end
        end
    endtask

    // Caller sits at negedge+1 of an IDLE cycle; returns at negedge+1 of the
    // IDLE cycle after the response.
    task automatic do_txn(input bit is_d, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input int lat,
                          input logic [31:0] exp_rdata, input bit exp_err, input int exp_dur);
        mem_t  m;
        resp_t r;
        int    target;
        m.wr = is_d && we; m.addr = addr; m.wdata = wdata; m.dur = exp_dur;
        exp_mem.push_back(m);
        r.is_d = is_d; r.rdata = exp_rdata; r.err = exp_err;
        exp_resp.push_back(r);
        mem_lat = lat;
        target  = n_resp + 1;
        if (is_d) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        end else begin
            i_req = 1'b1; i_addr = addr;
        end
        @(negedge clk); #1;
        chk("req_to_strobe_latency", mem_rd_en || mem_wr_en, 1);
        for (int k = 0; k < 40 && n_resp < target; k++) begin
            @(negedge clk); #1;
        end
        chk("ack_within_budget", n_resp >= target, 1);
        i_req = 1'b0;
        d_req = 1'b0;
        @(negedge clk); #1;
        chk("busy_after_resp", busy, 0);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk); #1;
        rst = 1'b0;
        @(negedge clk); #1;
    endtask

    initial begin
        mem_t  m;
        resp_t r;
        int    target;
        n_chk = 0; n_err = 0; n_resp = 0;
        mem_lat = 1; idle_pulse = 1'b0;
        rst = 1'b1;
        i_req = 1'b0; i_addr = 32'h0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
        mem_ack = 1'b0; mem_rdata = 32'h0;
        fork
            responder();
            monitor();
        join_none

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_strobes", {mem_rd_en, mem_wr_en}, 2'b00);
        chk("rst_acks", {i_ack, d_ack, err, timeout_err}, 4'b0000);
        chk("rst_mem_addr", mem_addr, 32'h0);
        rst = 1'b0;
        @(negedge clk); #1;

        // Test 1: reset mid BUSY_D write
        m.wr = 1'b1; m.addr = 32'h80; m.wdata = 32'hCAFE0001; m.dur = 0;
        exp_mem.push_back(m);
        mem_lat = 0;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'hCAFE0001;
        @(negedge clk); #1;
        chk("t1_wr_en_before_rst", mem_wr_en, 1);
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        chk("t1_async_strobes", {mem_rd_en, mem_wr_en}, 2'b00);
        chk("t1_async_addr_wdata", {mem_addr, mem_wdata}, 64'h0);
        chk("t1_async_busy", busy, 0);
        d_req = 1'b0; d_we = 1'b0;
        @(negedge clk); #1;
        rst = 1'b0;
        @(negedge clk); #1;
        chk("t1_idle_after_rst", {busy, mem_rd_en, mem_wr_en}, 3'b000);

        // Test 3: D write 0x40; memory data is captured but ignored by D-cache
        do_txn(1'b1, 1'b1, 32'h40, 32'h12345678, 2, 32'h0040BEEF, 1'b0, 2);

        // Test 2: I read 0x100, ack 4 cycles after strobe
        do_txn(1'b0, 1'b0, 32'h100, 32'h0, 4, 32'hDEADBEEF, 1'b0, 4);

        // Test 4: last grant was I; reset must restore last_grant=D so I wins first tie
        pulse_reset();
        mem_lat = 1;
        for (int k = 0; k < 4; k++) begin
            m.wr = 1'b0; m.wdata = 32'h0; m.dur = 1;
            m.addr = (k % 2 == 0) ? 32'h200 : 32'h300;
            exp_mem.push_back(m);
            r.is_d = (k % 2 == 1); r.err = 1'b0;
            r.rdata = (k % 2 == 0) ? 32'h0200BEEF : 32'h0300BEEF;
            exp_resp.push_back(r);
        end
        target = n_resp + 4;
        i_req = 1'b1; i_addr = 32'h200;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
        for (int k = 0; k < 60 && n_resp < target; k++) begin
            @(negedge clk); #1;
        end
        chk("t4_four_acks", n_resp >= target, 1);
        i_req = 1'b0; d_req = 1'b0;
        @(negedge clk); #1;
        chk("t4_busy_after", busy, 0);

        // Test 6a: mem_ack while IDLE is ignored
        idle_pulse = 1'b1;
        repeat (2) begin
            @(negedge clk); #1;
            chk("t6_idle_ack_no_effect", {busy, i_ack, d_ack, mem_rd_en, mem_wr_en}, 5'b00000);
        end
        idle_pulse = 1'b0;
        @(negedge clk); #1;

        // Test 6b: mem_ack on the exact timeout cycle completes normally
        do_txn(1'b1, 1'b0, 32'h500, 32'h0, 8, 32'h0500BEEF, 1'b0, 8);
        chk("t6_no_timeout_err", timeout_err, 0);

        // Test 5: no mem_ack -> abort after 8 BUSY cycles
        do_txn(1'b1, 1'b0, 32'h600, 32'h0, 0, 32'h0, 1'b1, 8);
        chk("t5_timeout_err_set", timeout_err, 1);
        do_txn(1'b0, 1'b0, 32'h100, 32'h0, 2, 32'hDEADBEEF, 1'b0, 2);
        chk("t5_timeout_err_sticky", timeout_err, 1);
        pulse_reset();
        chk("t5_timeout_err_cleared", timeout_err, 0);

        chk("exp_mem_drained", exp_mem.size(), 0);
        chk("exp_resp_drained", exp_resp.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
